gh_fixed512_sched: RTL and testbench
====================================

# gh_fixed512_sched

Request scheduler and flow controller for the fixed-512 GOST hash pipeline. It arbitrates round-robin among NREQ requesters that each present one 512-bit block. It drives the pipeline's clock enable and data input, and tracks every in-flight block with a shadow valid/tag shift register. Results come back on a single valid/ready output port tagged with source index and sequence number. The block sits directly in front of and behind one `gh_fixed512_logic` instance.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters (1..8).
- `LATENCY`, default 120: core latency in `clken`-qualified cycles. It must equal the instantiated core's data_in→hash_out latency.
- `SEQ_W`, default 8: width of the sequence tag.

Ports:
- `clk`  in  1  single clock. Clock domain is `clk` only.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  admission enable. When low, no new grants are issued and the pipeline keeps draining.
- `req_valid`  in  NREQ  per-requester block valid.
- `req_data`  in  NREQ×512  per-requester block, packed `[NREQ-1:0][511:0]`.
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero).
- `core_clken`  out  1  to core `clken`.
- `core_data_in`  out  512  to core `data_in`.
- `core_hash_out`  in  512  from core `hash_out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accept.
- `out_hash`  out  512  equals `core_hash_out`.
- `out_src`  out  $clog2(NREQ) (min 1)  requester index of the result.
- `out_seq`  out  SEQ_W  global accept sequence number of the result.
- `occupancy`  out  $clog2(LATENCY+1)  number of valid in-flight blocks.
- `idle`  out  1  high when occupancy==0.

## Operation
Shadow pipe:
- Shadow register of LATENCY entries `{v, src, seq}`.
- It shifts only when `core_clken`=1. Entry 0 loads the accept slot; entry LATENCY-1 is the tail.

Flow control:
- `core_clken = !tail.v || out_ready`. The whole core and shadow stall only when a valid result is blocked.
- Outputs: `out_valid = tail.v`, `out_src = tail.src`, `out_seq = tail.seq`, `out_hash = core_hash_out`.

Admission:
- A grant is possible only when `en && core_clken && |req_valid`.
- Round-robin: search starts at `last+1` mod NREQ. The first asserted `req_valid` wins.
- `req_ready` is asserted for the winner only.
- On grant:
  - `core_data_in = req_data[winner]`.
  - Entry 0 loads `{1, winner, seq_cnt}`.
  - `seq_cnt` increments, wrapping mod 2^SEQ_W.
  - `last` is set to winner.
- No grant while `core_clken`=1: `core_data_in` = 0 and entry 0 loads v=0 (bubble). `last` and `seq_cnt` hold.
- `core_clken`=0: no grant, `req_ready` = 0.

Counters:
- `occupancy` increments on grant without a tail pop.
- It decrements on a tail pop (`out_valid && out_ready`) without a grant.
- It holds when both or neither happen.
- It never exceeds LATENCY.

Requester rules:
- A requester must hold `req_valid` and `req_data` stable until `req_ready`.
- The scheduler never drops an accepted block.

## Timing
Reset values:
- All shadow `v` = 0, `last` = NREQ-1 (requester 0 has first priority), `seq_cnt` = 0, `occupancy` = 0.
- `idle` = 1, `out_valid` = 0, `req_ready` = 0.
- `core_clken` = 1 during reset, which flushes core garbage. `core_data_in` = 0.

Latency:
- A block accepted at edge t produces `out_valid` at cycle t+LATENCY, provided no stalls occur.
- Each stall cycle adds exactly one cycle.
- Throughput is one block per cycle. Results leave in accept order.

Boundary cases:
- Simultaneous grant and pop: both take effect, occupancy unchanged.
- Pop with tail valid and `out_ready`: a grant in the same cycle is allowed.
- `en` deasserted mid-stream: in-flight blocks drain normally and `idle` rises after the last pop.
- `rst` mid-operation: all in-flight results are discarded and no `out_valid` follows for them. The first post-reset accept gets seq 0.
- `seq_cnt` wrap from 2^SEQ_W-1 to 0 is legal.
- NREQ=1: `out_src` = 0 always.

## Test plan
- Single block: req0 presents `512'h1` at cycle 10 with `out_ready`=1.
  - `req_ready[0]` is high at 10.
  - `out_valid` is high at exactly cycle 130 (LATENCY 120) with `out_src`=0, `out_seq`=0, and `out_hash` matching the Streebog-512 model of `512'h1`.
  - `idle` returns to 1 at cycle 131.
- Round-robin: req0 and req1 both hold valid for 6 cycles.
  - Grants alternate 0,1,0,1,0,1 and seqs run 0..5.
  - Results come out in the same order, back-to-back, each hash matching the model.
- Backpressure: stream 10 blocks, then hold `out_ready`=0 for 20 cycles once the first result is valid.
  - `core_clken`=0 and `req_ready`=0 throughout the hold.
  - `out_hash` stays stable.
  - No result is lost or duplicated. The final result appears 20 cycles later than the unstalled case.
- Drain: drop `en` after 5 accepts while requests stay valid.
  - No further `req_ready`.
  - Exactly 5 results are produced, occupancy counts 5→0, and `idle`=1 afterwards.
- Reset mid-flight: assert `rst` for 1 cycle with 50 blocks in flight.
  - `out_valid` stays 0 for the next LATENCY cycles with no new requests.
  - The next accept has `out_seq`=0 and requester 0 wins a tie.
- Seq wrap: 300 consecutive blocks with SEQ_W=8.
  - `out_seq` runs 255→0→1.
  - Occupancy peaks at 120.

Source files
------------

// File: rtl/gh_fixed512_sched.sv
// Round-robin admission and valid/ready flow control around one fixed-512 hash core.
// A shadow shift register tracks {valid, source, sequence} of each block in the core pipeline.
module gh_fixed512_sched #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 120,
    parameter int SEQ_W   = 8,
    localparam int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int OCC_W  = $clog2(LATENCY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][511:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       core_clken,
    output logic [511:0]               core_data_in,
    input  logic [511:0]               core_hash_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [511:0]               out_hash,
    output logic [SRC_W-1:0]           out_src,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [OCC_W-1:0]           occupancy,
    output logic                       idle
);

    logic [LATENCY-1:0] sh_v;
    logic [SRC_W-1:0]   sh_src [LATENCY];
    logic [SEQ_W-1:0]   sh_seq [LATENCY];

    logic [SRC_W-1:0]   last;
    logic [SEQ_W-1:0]   seq_cnt;
    logic [SRC_W-1:0]   win;
    logic               found;
    logic               grant;
    logic               pop;
    logic               tail_v;

    assign tail_v     = sh_v[LATENCY-1];
    // Reset forces the enable high so the core flushes whatever it held.
    assign core_clken = rst || !tail_v || out_ready;
    assign pop        = tail_v && out_ready;

    assign out_valid  = tail_v;
    assign out_src    = sh_src[LATENCY-1];
    assign out_seq    = sh_seq[LATENCY-1];
    assign out_hash   = core_hash_out;
    assign idle       = (occupancy == '0);

    // Priority order is last+1, last+2, ... wrapping; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (((int'(last) + k) % NREQ) == i)) begin
                    found = 1'b1;
                    win   = SRC_W'(i);
                end
            end
        end
    end

    assign grant = en && core_clken && !rst && found;

    always_comb begin
        req_ready    = '0;
        core_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && (win == SRC_W'(i))) begin
                req_ready[i] = 1'b1;
                core_data_in = req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v      <= '0;
            last      <= SRC_W'(NREQ - 1);
            seq_cnt   <= '0;
            occupancy <= '0;
        end else begin
            if (core_clken) begin
                sh_v <= {sh_v[LATENCY-2:0], grant};
            end
            if (grant) begin
                last    <= win;
                seq_cnt <= seq_cnt + SEQ_W'(1);
            end
            if (grant && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (pop && !grant) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    // Tags carry no reset; they are only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (core_clken) begin
            sh_src[0] <= grant ? win : '0;
            sh_seq[0] <= grant ? seq_cnt : '0;
            for (int i = 1; i < LATENCY; i++) begin
                sh_src[i] <= sh_src[i-1];
                sh_seq[i] <= sh_seq[i-1];
            end
        end
    end

endmodule

// File: tb/tb_gh_fixed512_sched.sv
// Directed bench for gh_fixed512_sched with a stand-in core (delay line plus XOR mask).
// Table vectors cover arbitration; hand-written sequences cover latency, stall, drain, reset and wrap.
module tb_gh_fixed512_sched;

    localparam int NREQ = 3;
    localparam int LAT  = 120;
    localparam int SEQW = 8;
    localparam logic [511:0] MASK = {8{64'hF0E1D2C3B4A59687}};

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][511:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   core_clken;
    logic [511:0]           core_data_in;
    logic [511:0]           core_hash_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [511:0]           out_hash;
    logic [1:0]             out_src;
    logic [SEQW-1:0]        out_seq;
    logic [6:0]             occupancy;
    logic                   idle;

    gh_fixed512_sched #(.NREQ(NREQ), .LATENCY(LAT), .SEQ_W(SEQW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .core_clken(core_clken), .core_data_in(core_data_in),
        .core_hash_out(core_hash_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
        .out_src(out_src), .out_seq(out_seq),
        .occupancy(occupancy), .idle(idle)
    );

    always #5 clk = ~clk;

    logic [511:0] cpipe [LAT];
    always @(posedge clk) begin
        if (core_clken) begin
            cpipe[0] <= core_data_in;
            for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign core_hash_out = cpipe[LAT-1] ^ MASK;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   src;
        logic [7:0]   seq;
        logic [511:0] hash;
    } exp_t;

    typedef struct {
        bit         en;
        logic [2:0] rv;
        logic [2:0] rdy;
        int         occ;
    } vec_t;

    exp_t expq[$];
    exp_t e;
    int tests = 0;
    int fails = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    int exp_seq = 0;

    function automatic logic [511:0] dat(int k);
        return {16{32'(k) ^ 32'h5A5A0000}};
    endfunction

    function automatic logic [511:0] hmodel(logic [511:0] d);
        return d ^ MASK;
    endfunction

    task automatic chk(string name, logic [511:0] act, logic [511:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(logic [1:0] s, logic [511:0] d);
        expq.push_back('{s, exp_seq[7:0], hmodel(d)});
        exp_seq++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        exp_seq = 0;
        expq.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && (expq.size() != 0 || !idle); k++) tick();
        @(negedge clk);
        chk("drain_empty", 512'(expq.size()), 0);
        chk("drain_idle", idle, 1);
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got src=%0d seq=%0d expected none",
                         out_src, out_seq);
            end else begin
                e = expq.pop_front();
                chk("res_src", out_src, e.src);
                chk("res_seq", out_seq, e.seq);
                chk("res_hash", out_hash, e.hash);
            end
        end
    end

    initial begin
        vec_t vecs[12];
        logic [511:0] ed;
        logic [511:0] hold_hash;
        logic [1:0] w;
        bit fnd;
        int g0, p0, bad, maxocc, prev;

        vecs[0]  = '{1'b1, 3'b000, 3'b000, 0};
        vecs[1]  = '{1'b1, 3'b111, 3'b001, 0};
        vecs[2]  = '{1'b1, 3'b111, 3'b010, 1};
        vecs[3]  = '{1'b1, 3'b111, 3'b100, 2};
        vecs[4]  = '{1'b1, 3'b101, 3'b001, 3};
        vecs[5]  = '{1'b1, 3'b101, 3'b100, 4};
        vecs[6]  = '{1'b0, 3'b111, 3'b000, 5};
        vecs[7]  = '{1'b1, 3'b010, 3'b010, 5};
        vecs[8]  = '{1'b1, 3'b010, 3'b010, 6};
        vecs[9]  = '{1'b1, 3'b100, 3'b100, 7};
        vecs[10] = '{1'b1, 3'b011, 3'b001, 8};
        vecs[11] = '{1'b1, 3'b000, 3'b000, 9};

        rst = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) req_data[i] = dat(100 + i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_clken", core_clken, 1);
        chk("rst_data_in", core_data_in, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_occupancy", occupancy, 0);
        tick();
        rst = 1'b0;
        req_valid = '0;

        // arbitration table
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            req_valid = vecs[i].rv;
            @(negedge clk);
            fnd = 1'b0;
            w = '0;
            for (int j = 0; j < NREQ; j++) begin
                if (vecs[i].rdy[j]) begin
                    fnd = 1'b1;
                    w = 2'(j);
                end
            end
            ed = fnd ? req_data[w] : '0;
            chk("tbl_ready", req_ready, vecs[i].rdy);
            chk("tbl_data_in", core_data_in, ed);
            chk("tbl_occupancy", occupancy, 512'(vecs[i].occ));
            if (fnd) push(w, ed);
            tick();
        end
        req_valid = '0;
        en = 1'b1;
        drain();

        // single block latency
        do_reset();
        repeat (8) tick();
        req_data[0] = 512'h1;
        req_valid = 3'b001;
        @(negedge clk);
        chk("single_ready", req_ready, 3'b001);
        push(2'd0, 512'h1);
        g0 = cyc;
        tick();
        req_valid = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
        end
        chk("single_latency", 512'(cyc - g0), 512'(LAT));
        tick();
        @(negedge clk);
        chk("single_idle", idle, 1);
        tick();
        req_data[0] = dat(100);

        // round robin between two requesters
        do_reset();
        req_valid = 3'b011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", req_ready, (k % 2) ? 3'b010 : 3'b001);
            push(2'(k % 2), req_data[k % 2]);
            if (k == 0) g0 = cyc;
            tick();
        end
        req_valid = '0;
        drain();
        chk("rr_back_to_back", 512'(last_pop_cyc - g0), 512'(LAT + 5));

        // backpressure
        do_reset();
        out_ready = 1'b0;
        req_data[1] = dat(777);
        for (int k = 0; k < 10; k++) begin
            req_data[0] = dat(200 + k);
            req_valid = 3'b001;
            @(negedge clk);
            chk("bp_stream_ready", req_ready, 3'b001);
            push(2'd0, req_data[0]);
            if (k == 0) g0 = cyc;
            tick();
        end
        req_valid = '0;
        p0 = pops;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
        end
        chk("bp_first_valid", 512'(cyc - g0), 512'(LAT));
        hold_hash = out_hash;
        for (int s = 0; s < 20; s++) begin
            if (s > 0) @(negedge clk);
            chk("bp_hold_clken", core_clken, 0);
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_hash", out_hash, hold_hash);
            tick();
            if (s == 0) req_valid = 3'b010;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready, 3'b010);
        push(2'd1, dat(777));
        tick();
        req_valid = '0;
        for (int k = 0; k < 100 && pops < p0 + 10; k++) @(posedge clk);
        chk("bp_tenth_pop", 512'(last_pop_cyc - g0), 512'(9 + LAT + 20));
        drain();
        chk("bp_pop_total", 512'(pops - p0), 11);

        // drain after disabling admission
        do_reset();
        req_data[0] = dat(100);
        req_valid = 3'b011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("drn_ready", req_ready, (k % 2) ? 3'b010 : 3'b001);
            push(2'(k % 2), req_data[k % 2]);
            tick();
        end
        en = 1'b0;
        p0 = pops;
        @(negedge clk);
        chk("drn_occ5", occupancy, 5);
        bad = 0;
        prev = occupancy;
        for (int k = 0; k < LAT + 10; k++) begin
            tick();
            @(negedge clk);
            if (req_ready != 0) bad++;
            if (occupancy > prev) bad++;
            prev = occupancy;
        end
        chk("drn_no_ready", 512'(bad), 0);
        chk("drn_pops", 512'(pops - p0), 5);
        chk("drn_occ0", occupancy, 0);
        chk("drn_idle", idle, 1);
        tick();
        req_valid = '0;
        en = 1'b1;

        // reset with 50 blocks in flight
        do_reset();
        for (int k = 0; k < 50; k++) begin
            req_data[0] = dat(300 + k);
            req_valid = 3'b001;
            tick();
        end
        do_reset();
        bad = 0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            if (out_valid) bad++;
            tick();
        end
        chk("rstmid_no_valid", 512'(bad), 0);
        req_data[0] = dat(100);
        req_valid = 3'b011;
        @(negedge clk);
        chk("rstmid_tie", req_ready, 3'b001);
        push(2'd0, req_data[0]);
        tick();
        req_valid = '0;
        drain();

        // sequence wrap with full pipeline
        do_reset();
        maxocc = 0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            req_data[0] = dat(1000 + k);
            req_valid = 3'b001;
            @(negedge clk);
            if (req_ready != 3'b001) bad++;
            if (int'(occupancy) > maxocc) maxocc = occupancy;
            push(2'd0, req_data[0]);
            tick();
        end
        req_valid = '0;
        chk("wrap_ready", 512'(bad), 0);
        chk("wrap_occ_peak", 512'(maxocc), 512'(LAT));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
